// File: rtl/updn_cntr_pkg.sv
// Shared definitions for the up/down counter: state-register width and state codes.
// The RTL and the testbench both import this package.
package updn_cntr_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 3'b000,
        S_LOAD = 3'b001,
        S_INC  = 3'b010,
        S_INC2 = 3'b011,
        S_DEC  = 3'b100,
        S_DEC2 = 3'b101
    } state_t;

endpackage

// File: rtl/updn_cntr_ns_logic.sv
// Next-state decode for updn_cntr, written as gate primitives.
// Unused codes 110/111 fall out of the equations exactly like IDLE.
module ns_logic
    import updn_cntr_pkg::*;
(
    input  logic [STATE_W-1:0] state,
    input  logic               load,
    input  logic               inc,
    output logic [STATE_W-1:0] next_state
);

    logic s0_n, s1_n, s2_n;
    logic load_n, inc_n;
    logic in_inc, in_dec;
    logic up_second, dn_second;

    not u_not_s0   (s0_n,   state[0]);
    not u_not_s1   (s1_n,   state[1]);
    not u_not_s2   (s2_n,   state[2]);
    not u_not_load (load_n, load);
    not u_not_inc  (inc_n,  inc);

    // Only the exact INC / DEC codes advance to their second-phase state.
    and u_in_inc (in_inc, s2_n, state[1], s0_n);
    and u_in_dec (in_dec, state[2], s1_n, s0_n);

    and u_up_second (up_second, inc,   in_inc);
    and u_dn_second (dn_second, inc_n, in_dec);

    or  u_ns0 (next_state[0], load, up_second, dn_second);
    and u_ns1 (next_state[1], load_n, inc);
    and u_ns2 (next_state[2], load_n, inc_n);

endmodule

// File: rtl/updn_cntr.sv
// Loadable up/down counter with a six-state control FSM; state and data register together.
// The counter operation is chosen by the next state, so d_out and o_state move on the same edge.
module updn_cntr
    import updn_cntr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               inc,
    input  logic [WIDTH-1:0]   d_in,
    output logic [WIDTH-1:0]   d_out,
    output logic [STATE_W-1:0] o_state
);

    state_t               state_q, state_d;
    logic [STATE_W-1:0]   ns_raw;
    logic [WIDTH-1:0]     d_out_q, d_out_d;

    ns_logic u_ns_logic (
        .state      (state_q),
        .load       (load),
        .inc        (inc),
        .next_state (ns_raw)
    );

    assign state_d = state_t'(ns_raw);

    always_comb begin
        // NOTE: default first so every path assigns d_out_d and no latch is inferred.
        d_out_d = d_out_q;
        case (state_d)
            S_LOAD:         d_out_d = d_in;
            S_INC, S_INC2:  d_out_d = d_out_q + WIDTH'(1);
            S_DEC, S_DEC2:  d_out_d = d_out_q - WIDTH'(1);
            default:        d_out_d = d_out_q;
        endcase
    end

    // NOTE: non-blocking assignments so all flops sample their _d values from the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            d_out_q <= '0;
        end else begin
            state_q <= state_d;
            d_out_q <= d_out_d;
        end
    end

    assign d_out   = d_out_q;
    assign o_state = state_q;

endmodule

// File: doc/updn_cntr.md
UPDN_CNTR -- requirements
Module: updn_cntr

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have parameter WIDTH, default 8, setting the counter data width in bits.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port load  input  1  load request; highest priority after reset.
REQ-006 The block SHALL have port inc  input  1  direction select: 1 = count up, 0 = count down.
REQ-007 The block SHALL have port d_in  input  WIDTH  load value.
REQ-008 The block SHALL have port d_out  output  WIDTH  registered counter value.
REQ-009 The block SHALL have port o_state  output  3  registered current FSM state code.

Function
REQ-010 The FSM SHALL have six states: IDLE=3'b000, LOAD=3'b001, INC=3'b010, INC2=3'b011, DEC=3'b100, DEC2=3'b101.
REQ-011 Codes 3'b110 and 3'b111 SHALL be unreachable; if present, the FSM SHALL treat them as IDLE for next-state decode.
REQ-012 When load=1, the next state SHALL be LOAD from every state, regardless of inc.
REQ-013 When load=0 and inc=1, the next state SHALL be INC2 from INC.
REQ-014 When load=0 and inc=1, the next state SHALL be INC from INC2, IDLE, LOAD, DEC and DEC2.
REQ-015 When load=0 and inc=0, the next state SHALL be DEC2 from DEC.
REQ-016 When load=0 and inc=0, the next state SHALL be DEC from DEC2, IDLE, LOAD, INC and INC2.
REQ-017 The counter operation SHALL be selected by the next state and applied on the same edge that updates the state.
REQ-018 For the counter operation: LOAD SHALL give d_out<=d_in; INC/INC2 SHALL give d_out<=d_out+1; DEC/DEC2 SHALL give d_out<=d_out-1; IDLE SHALL hold d_out.
REQ-019 Latency SHALL be one cycle: inputs sampled at edge N appear on d_out/o_state after edge N, with d_out and o_state changing together.
REQ-020 Arithmetic SHALL be modulo 2^WIDTH: all-ones+1 -> 0 and 0-1 -> all-ones, with no carry or borrow output.
REQ-021 Consecutive load cycles SHALL reload d_in each cycle, staying in LOAD.
REQ-022 Toggling inc every cycle SHALL alternate INC/DEC without an intermediate IDLE.
REQ-023 No output SHALL depend combinationally on inputs.

Reset
REQ-024 With reset=1 at a rising edge, the block SHALL set state=IDLE, o_state=3'b000 and d_out=0 on that edge.
REQ-025 Reset SHALL override load and inc.
REQ-026 Reset SHALL take effect only on a clock edge; asserting it mid-cycle SHALL have no effect until the edge.
REQ-027 Reset asserted mid-count SHALL discard the count, with no residual state.
REQ-028 The first edge after reset deasserts SHALL follow REQ-012..REQ-016 from IDLE.

Structure
REQ-029 State codes (IDLE..DEC2) and the state-register width (3) SHALL live in a shared package/header used by both RTL and bench.
REQ-030 Next-state decode SHALL be one sub-module, ns_logic (inputs: current state, load, inc; output: next state), built from the team's gate primitives.
REQ-031 The state register, data register, and increment/decrement datapath SHALL reside in updn_cntr.

Verification
REQ-032 The bench SHALL check reset: reset=1 with load=1, d_in=8'hAA for one edge -> d_out=8'h00, o_state=000.
REQ-033 The bench SHALL check load then count up: load=1, d_in=8'h05 for one edge, then load=0, inc=1 for three edges -> d_out=06,07,08 with o_state=INC,INC2,INC.
REQ-034 The bench SHALL check wrap-around: load 8'hFE, then inc=1 for two edges -> FF then 00; load 8'h01, then inc=0 for two edges -> 00 then FF.
REQ-035 The bench SHALL check load priority: in INC2, load=1 with inc=1 and d_in=8'h3C -> o_state=LOAD, d_out=8'h3C.
REQ-036 The bench SHALL check direction toggle: from DEC2 at 8'h10, inc=1 -> o_state=INC, d_out=8'h11; then inc=0 -> o_state=DEC, d_out=8'h10.
REQ-037 The bench SHALL check reset mid-operation: in DEC with d_out=8'h40, reset=1 for one edge -> IDLE/00; then inc=1 -> INC/01.
